// File: rtl/rtc_counter_if.sv
// MMIO request bus into the RTC time base: store/load strobes, byte address
// and store data. The CPU side drives it (master); rtc_counter samples it (slave).
// A store is one cycle with wWriteEnable high and takes effect on the next rising
// edge. A load is a level on wReadEnable, and the result is combinational.
// There is no ready or stall: the block accepts every request in the cycle it appears.
interface rtc_counter_if;
  logic        wWriteEnable;
  logic        wReadEnable;
  logic [31:0] wAddress;
  logic [31:0] wWriteData;

  modport master (
    output wWriteEnable,
    output wReadEnable,
    output wAddress,
    output wWriteData
  );

  modport slave (
    input wWriteEnable,
    input wReadEnable,
    input wAddress,
    input wWriteData
  );
endinterface

// File: rtl/rtc_counter.sv
// Millisecond time base for the RTC MMIO path.
// The prescaler divides the core clock by DIV = CLOCK_FREQ/TICK_HZ (DIV >= 2).
// Each time the prescaler wraps, the 32-bit miliseconds count advances and tick
// pulses for one cycle.
// MMIO registers:
//   BASE+0 : count preset (write only)
//   BASE+4 : alarm compare
//   BASE+8 : bit0 enable, bit1 pending (write 1 to clear)
// Define RTC_ALARM_EN to build the alarm registers and alarm_irq. Without it,
// BASE+4 and BASE+8 are absent and alarm_irq is tied to 0.
module rtc_counter #(
  parameter int          CLOCK_FREQ   = 50_000_000,
  parameter int          TICK_HZ      = 1000,
  parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  rtc_counter_if.slave bus,
  output logic [31:0] wReadData,
  output logic [31:0] miliseconds,
  output logic        tick,
  output logic        alarm_irq
);

  localparam int DIV = CLOCK_FREQ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] prescaler;
  logic          sel_count;
  logic          preset;
  logic          wrap;
  logic          tick_now;
  logic [31:0]   ms_inc;

  // The address decode is an exact match on all 32 bits.
  assign sel_count = (bus.wAddress == BASE_ADDRESS);
  assign preset    = bus.wWriteEnable & sel_count;
  assign wrap      = (prescaler == LAST);
  // A preset store wins over a tick in the same cycle, and that tick is lost.
  assign tick_now  = wrap & ~preset;
  assign ms_inc    = miliseconds + 32'd1;

  // Prescaler, count and tick pulse. A preset also restarts the prescaler phase.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler   <= '0;
      miliseconds <= '0;
      tick        <= 1'b0;
    end else begin
      tick <= tick_now;
      if (preset) begin
        prescaler   <= '0;
        miliseconds <= bus.wWriteData;
      end else if (wrap) begin
        prescaler   <= '0;
        miliseconds <= ms_inc;
      end else begin
        prescaler   <= prescaler + PW'(1);
      end
    end
  end

`ifdef RTC_ALARM_EN
  logic [31:0] alarm_compare;
  logic        alarm_enable;
  logic        alarm_pending;
  logic        sel_cmp;
  logic        sel_ctrl;
  logic        alarm_match;
  logic        rd_hit;
  logic [31:0] rd_val;

  assign sel_cmp  = (bus.wAddress == BASE_ADDRESS + 32'd4);
  assign sel_ctrl = (bus.wAddress == BASE_ADDRESS + 32'd8);
  // The alarm can match only on a real increment, so a preset never raises it.
  // A compare of 0 therefore matches on the FFFFFFFF -> 0 wrap.
  assign alarm_match = tick_now & alarm_enable & (ms_inc == alarm_compare);

  // Alarm registers. When a new match and a write-1-clear land together, the match wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alarm_compare <= 32'hFFFF_FFFF;
      alarm_enable  <= 1'b0;
      alarm_pending <= 1'b0;
    end else begin
      if (bus.wWriteEnable && sel_cmp) begin
        alarm_compare <= bus.wWriteData;
      end
      if (bus.wWriteEnable && sel_ctrl) begin
        alarm_enable <= bus.wWriteData[0];
      end
      if (alarm_match) begin
        alarm_pending <= 1'b1;
      end else if (bus.wWriteEnable && sel_ctrl && bus.wWriteData[1]) begin
        alarm_pending <= 1'b0;
      end
    end
  end

  assign alarm_irq = alarm_pending & alarm_enable;

  // Read mux for the alarm registers. A matched address without a load strobe returns 1.
  always_comb begin
    rd_hit = 1'b0;
    rd_val = 32'd0;
    if (sel_cmp) begin
      rd_hit = 1'b1;
      rd_val = bus.wReadEnable ? alarm_compare : 32'd1;
    end else if (sel_ctrl) begin
      rd_hit = 1'b1;
      rd_val = bus.wReadEnable ? {30'd0, alarm_pending, alarm_enable} : 32'd1;
    end
  end

  // The count register is read through the RTC read interface, so BASE+0 stays released here.
  assign wReadData = rd_hit ? rd_val : 32'hzzzz_zzzz;
`else
  // Without the alarm, nothing is readable here and the load strobe has no use.
  logic unused_read;
  assign unused_read = bus.wReadEnable;
  assign alarm_irq   = 1'b0;
  assign wReadData   = 32'hzzzz_zzzz;
`endif

endmodule
